// File: rtl/cache_dados_nway_if.sv
// CPU-side request/response bus of the N-way data cache.
// The master modport is the CPU; the slave modport is the cache.
interface cache_dados_nway_if #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 64
);
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] address;
   logic [WORD_W-1:0] write_data;
   logic [WORD_W-1:0] read_data;
   logic              ready;
   logic              miss;

   modport master (
      output mem_read, mem_write, address, write_data,
      input  read_data, ready, miss
   );

   modport slave (
      input  mem_read, mem_write, address, write_data,
      output read_data, ready, miss
   );
endinterface

// File: rtl/cache_dados_nway.sv
// Set-associative write-back/write-allocate data cache with per-set age LRU.
// Each request is looked up in COMPARE; a miss optionally writes back the victim, then refills it.
module cache_dados_nway #(
   parameter int ADDR_W      = 32,
   parameter int WORD_W      = 64,
   parameter int BLOCK_WORDS = 2,
   parameter int SETS        = 4,
   parameter int WAYS        = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   cache_dados_nway_if.slave             cpu,
   output logic [ADDR_W-1:0]             mem_address,
   output logic [WORD_W*BLOCK_WORDS-1:0] mem_write_data,
   input  logic [WORD_W*BLOCK_WORDS-1:0] mem_block_read_data,
   input  logic                          mem_ready,
   output logic                          mem_read_out,
   output logic                          mem_write_out,
   output logic [31:0]                   hit_count,
   output logic [31:0]                   miss_count
);
   localparam int BLOCK_W = WORD_W * BLOCK_WORDS;
   localparam int BYTE_W  = $clog2(WORD_W / 8);
   localparam int WSEL_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam int OFF_W   = BYTE_W + $clog2(BLOCK_WORDS);
   localparam int IDX_W   = $clog2(SETS);
   localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
   localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

   state_t                   state_q, state_d;
   logic [TAG_W-1:0]         tag_q, tag_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [WSEL_W-1:0]        wsel_q, wsel_d;
   logic [WORD_W-1:0]        wdata_q, wdata_d;
   logic                     is_write_q, is_write_d;
   logic                     first_q, first_d;
   logic [WAY_W-1:0]         victim_q, victim_d;
   logic [WORD_W-1:0]        read_data_q, read_data_d;
   logic                     ready_q, ready_d;
   logic                     miss_q, miss_d;
   logic                     mem_read_q, mem_read_d;
   logic                     mem_write_q, mem_write_d;
   logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
   logic [BLOCK_W-1:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]              hit_cnt_q, hit_cnt_d;
   logic [31:0]              miss_cnt_q, miss_cnt_d;
   logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
   logic [SETS-1:0][WAYS-1:0] dirty_q, dirty_d;
   logic [WAY_W-1:0]         age_q [SETS][WAYS];
   logic [WAY_W-1:0]         age_d [SETS][WAYS];

   logic [TAG_W-1:0]         tag_mem  [SETS][WAYS];
   logic [BLOCK_W-1:0]       data_mem [SETS][WAYS];

   logic [WAYS-1:0]          way_hit;
   logic                     hit;
   logic [WAY_W-1:0]         hit_way;
   logic [WAY_W-1:0]         victim;
   logic                     found_inv;
   logic                     word_we;
   logic                     fill_we;

   for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_cmp
      assign way_hit[gi] = valid_q[idx_q][gi] && (tag_mem[idx_q][gi] == tag_q);
   end

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      victim    = '0;
      found_inv = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (way_hit[w] && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[idx_q][w] && !found_inv) begin
            found_inv = 1'b1;
            victim    = WAY_W'(w);
         end
      end
      if (!found_inv) begin
         for (int w = 1; w < WAYS; w++) begin
            if (age_q[idx_q][w] > age_q[idx_q][victim]) victim = WAY_W'(w);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      idx_d       = idx_q;
      wsel_d      = wsel_q;
      wdata_d     = wdata_q;
      is_write_d  = is_write_q;
      first_d     = first_q;
      victim_d    = victim_q;
      read_data_d = read_data_q;
      ready_d     = 1'b0;
      miss_d      = miss_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      age_d       = age_q;
      word_we     = 1'b0;
      fill_we     = 1'b0;
      case (state_q)
         IDLE: begin
            // ready_q blocks re-accepting the request the CPU is still holding after completion
            if ((cpu.mem_read || cpu.mem_write) && !ready_q) begin
               tag_d      = cpu.address[ADDR_W-1 -: TAG_W];
               idx_d      = cpu.address[OFF_W +: IDX_W];
               wsel_d     = cpu.address[BYTE_W +: WSEL_W] & WSEL_W'(BLOCK_WORDS - 1);
               wdata_d    = cpu.write_data;
               is_write_d = cpu.mem_write;
               first_d    = 1'b1;
               state_d    = COMPARE;
            end
         end
         COMPARE: begin
            first_d = 1'b0;
            if (hit) begin
               state_d = IDLE;
               ready_d = 1'b1;
               miss_d  = 1'b0;
               if (first_q) hit_cnt_d = hit_cnt_q + 32'd1;
               for (int w = 0; w < WAYS; w++) begin
                  if (w == int'(hit_way)) age_d[idx_q][w] = '0;
                  else if (age_q[idx_q][w] < age_q[idx_q][hit_way]) age_d[idx_q][w] = age_q[idx_q][w] + 1'b1;
               end
               if (is_write_q) begin
                  word_we                  = 1'b1;
                  dirty_d[idx_q][hit_way]  = 1'b1;
               end else begin
                  read_data_d = data_mem[idx_q][hit_way][wsel_q*WORD_W +: WORD_W];
               end
            end else begin
               if (first_q) miss_cnt_d = miss_cnt_q + 32'd1;
               miss_d   = 1'b1;
               victim_d = victim;
               if (valid_q[idx_q][victim] && dirty_q[idx_q][victim]) begin
                  state_d     = WRITEBACK;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {tag_mem[idx_q][victim], idx_q, {OFF_W{1'b0}}};
                  mem_wdata_d = data_mem[idx_q][victim];
               end else begin
                  state_d    = ALLOCATE;
                  mem_read_d = 1'b1;
                  mem_addr_d = {tag_q, idx_q, {OFF_W{1'b0}}};
               end
            end
         end
         WRITEBACK: begin
            if (mem_ready) begin
               state_d     = ALLOCATE;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = {tag_q, idx_q, {OFF_W{1'b0}}};
            end
         end
         ALLOCATE: begin
            if (mem_ready) begin
               state_d                   = COMPARE;
               fill_we                   = 1'b1;
               mem_read_d                = 1'b0;
               miss_d                    = 1'b0;
               valid_d[idx_q][victim_q]  = 1'b1;
               dirty_d[idx_q][victim_q]  = 1'b0;
               // A fresh way starts oldest so its re-lookup hit ages every other way of the set
               age_d[idx_q][victim_q]    = WAY_W'(WAYS - 1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         tag_q       <= '0;
         idx_q       <= '0;
         wsel_q      <= '0;
         wdata_q     <= '0;
         is_write_q  <= 1'b0;
         first_q     <= 1'b0;
         victim_q    <= '0;
         read_data_q <= '0;
         ready_q     <= 1'b0;
         miss_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
         end
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         idx_q       <= idx_d;
         wsel_q      <= wsel_d;
         wdata_q     <= wdata_d;
         is_write_q  <= is_write_d;
         first_q     <= first_d;
         victim_q    <= victim_d;
         read_data_q <= read_data_d;
         ready_q     <= ready_d;
         miss_q      <= miss_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         age_q       <= age_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         data_mem[idx_q][victim_q] <= mem_block_read_data;
         tag_mem[idx_q][victim_q]  <= tag_q;
      end else if (word_we) begin
         data_mem[idx_q][hit_way][wsel_q*WORD_W +: WORD_W] <= wdata_q;
      end
   end

   assign cpu.read_data    = read_data_q;
   assign cpu.ready        = ready_q;
   assign cpu.miss         = miss_q;
   assign mem_address      = mem_addr_q;
   assign mem_write_data   = mem_wdata_q;
   assign mem_read_out     = mem_read_q;
   assign mem_write_out    = mem_write_q;
   assign hit_count        = hit_cnt_q;
   assign miss_count       = miss_cnt_q;
endmodule

// File: tb/tb_cache_dados_nway.sv
// Directed bench for cache_dados_nway: CPU requests with a read-data scoreboard
// and a behavioural memory that logs every strobe it answers.
module tb_cache_dados_nway;
   localparam logic [127:0] BLK0 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222;

   typedef struct packed {
      logic         wr;
      logic [31:0]  addr;
      logic [127:0] data;
   } mem_ev_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  mem_address;
   logic [127:0] mem_write_data;
   logic [127:0] mem_block_read_data;
   logic         mem_ready;
   logic         mem_read_out;
   logic         mem_write_out;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   int total = 0;
   int bad   = 0;
   int mem_lat = 1;

   logic [127:0] mem_model [logic [31:0]];
   logic [63:0]  shadow [logic [31:0]];
   logic [63:0]  exp_q [$];
   mem_ev_t      log_q [$];
   logic [63:0]  rd_model = '0;

   cache_dados_nway_if #(.ADDR_W(32), .WORD_W(64)) cpu ();

   cache_dados_nway #(
      .ADDR_W(32), .WORD_W(64), .BLOCK_WORDS(2), .SETS(4), .WAYS(2)
   ) dut (
      .clk                 (clk),
      .reset               (rst_n),
      .cpu                 (cpu),
      .mem_address         (mem_address),
      .mem_write_data      (mem_write_data),
      .mem_block_read_data (mem_block_read_data),
      .mem_ready           (mem_ready),
      .mem_read_out        (mem_read_out),
      .mem_write_out       (mem_write_out),
      .hit_count           (hit_count),
      .miss_count          (miss_count)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] blk_get(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      if (a == 32'h0) return BLK0;
      return {32'hB0B0_0000 ^ a, 32'h1111_0000 ^ a, 32'hC0C0_0000 ^ a, 32'h2222_0000 ^ a};
   endfunction

   function automatic logic [63:0] exp_word(input logic [31:0] a);
      logic [127:0] b;
      if (shadow.exists(a >> 3)) return shadow[a >> 3];
      b = blk_get(a & ~32'hF);
      return a[3] ? b[127:64] : b[63:0];
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory responder: answers each strobe after mem_lat further cycles, one mem_ready pulse per strobe
   initial begin
      int cnt;
      cnt = 0;
      mem_ready = 1'b0;
      mem_block_read_data = '0;
      forever begin
         @(negedge clk);
         if (!rst_n || mem_ready || !(mem_read_out || mem_write_out)) begin
            mem_ready = 1'b0;
            cnt = 0;
         end else begin
            cnt++;
            if (cnt > mem_lat) begin
               if (mem_write_out) begin
                  mem_model[mem_address] = mem_write_data;
                  log_q.push_back('{wr: 1'b1, addr: mem_address, data: mem_write_data});
               end else begin
                  mem_block_read_data = blk_get(mem_address);
                  log_q.push_back('{wr: 1'b0, addr: mem_address, data: mem_block_read_data});
               end
               mem_ready = 1'b1;
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      cpu.mem_read = 1'b0;
      cpu.mem_write = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      shadow.delete();
      exp_q.delete();
      rd_model = '0;
   endtask

   task automatic cpu_req(input logic wr, input logic [31:0] a, input logic [63:0] wd,
                          input logic exp_hit, input string tag);
      int ev0;
      int cyc;
      logic [63:0] e;
      ev0 = log_q.size();
      if (wr) begin
         exp_q.push_back(rd_model);
         shadow[a >> 3] = wd;
      end else begin
         rd_model = exp_word(a);
         exp_q.push_back(rd_model);
      end
      @(negedge clk);
      cpu.mem_read   = !wr;
      cpu.mem_write  = wr;
      cpu.address    = a;
      cpu.write_data = wd;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!cpu.ready && cyc < 200);
      cpu.mem_read  = 1'b0;
      cpu.mem_write = 1'b0;
      e = exp_q.pop_front();
      $display("txn %s %s addr=%h rd=%h cycles=%0d mem_ops=%0d", tag, wr ? "WR" : "RD", a,
               cpu.read_data, cyc, log_q.size() - ev0);
      chk({tag, "_ready"}, 128'(cpu.ready), 128'(1));
      chk({tag, "_rdata"}, 128'(cpu.read_data), 128'(e));
      chk({tag, "_miss_flag"}, 128'(cpu.miss), 128'(0));
      if (exp_hit) begin
         chk({tag, "_hit_latency"}, 128'(cyc), 128'(2));
         chk({tag, "_hit_no_mem"}, 128'(log_q.size() - ev0), 128'(0));
      end else begin
         chk({tag, "_miss_latency_gt2"}, 128'(cyc > 2), 128'(1));
      end
   endtask

   initial begin
      int ev0;
      int cyc;
      cpu.mem_read = 1'b0;
      cpu.mem_write = 1'b0;
      cpu.address = '0;
      cpu.write_data = '0;

      #1;
      chk("rst_read_data", 128'(cpu.read_data), 128'(0));
      chk("rst_ready", 128'(cpu.ready), 128'(0));
      chk("rst_miss", 128'(cpu.miss), 128'(0));
      chk("rst_strobes", 128'({mem_read_out, mem_write_out}), 128'(0));
      chk("rst_mem_address", 128'(mem_address), 128'(0));
      chk("rst_counters", 128'({hit_count, miss_count}), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // First read misses and fills; neighbour word then hits
      ev0 = log_q.size();
      cpu_req(1'b0, 32'h000, 64'h0, 1'b0, "rd000");
      chk("rd000_one_memop", 128'(log_q.size() - ev0), 128'(1));
      chk("rd000_memop_is_read", 128'(log_q[ev0].wr), 128'(0));
      chk("rd000_memop_addr", 128'(log_q[ev0].addr), 128'(32'h000));
      chk("rd000_value", 128'(cpu.read_data), 128'(64'hEEEE_FFFF_1111_2222));
      chk("rd000_miss_count", 128'(miss_count), 128'(1));
      cpu_req(1'b0, 32'h008, 64'h0, 1'b1, "rd008");
      chk("rd008_value", 128'(cpu.read_data), 128'(64'hAAAA_BBBB_CCCC_DDDD));
      chk("rd008_hit_count", 128'(hit_count), 128'(1));

      // Write hit then read-back
      cpu_req(1'b1, 32'h000, 64'h1234_5678_9ABC_DEF0, 1'b1, "wr000");
      chk("wr000_rdata_kept", 128'(cpu.read_data), 128'(64'hAAAA_BBBB_CCCC_DDDD));
      cpu_req(1'b0, 32'h000, 64'h0, 1'b1, "rd000b");
      chk("rd000b_value", 128'(cpu.read_data), 128'(64'h1234_5678_9ABC_DEF0));
      chk("counts_a", 128'({hit_count, miss_count}), 128'({32'd3, 32'd1}));

      // Clean conflict: LRU way (0x040) is replaced without writeback
      do_reset();
      chk("rst2_counters", 128'({hit_count, miss_count}), 128'(0));
      cpu_req(1'b0, 32'h000, 64'h0, 1'b0, "cc_rd000");
      chk("cc_dirty_discarded", 128'(cpu.read_data), 128'(64'hEEEE_FFFF_1111_2222));
      cpu_req(1'b0, 32'h040, 64'h0, 1'b0, "cc_rd040");
      cpu_req(1'b0, 32'h000, 64'h0, 1'b1, "cc_rd000_hit");
      ev0 = log_q.size();
      cpu_req(1'b0, 32'h080, 64'h0, 1'b0, "cc_rd080");
      chk("cc_080_one_memop", 128'(log_q.size() - ev0), 128'(1));
      chk("cc_080_no_writeback", 128'(log_q[ev0].wr), 128'(0));
      chk("cc_080_addr", 128'(log_q[ev0].addr), 128'(32'h080));
      cpu_req(1'b0, 32'h000, 64'h0, 1'b1, "cc_rd000_kept");
      cpu_req(1'b0, 32'h040, 64'h0, 1'b0, "cc_rd040_evicted");
      chk("cc_counts", 128'({hit_count, miss_count}), 128'({32'd2, 32'd4}));

      // Dirty eviction with a memory that answers in the strobe cycle
      do_reset();
      mem_lat = 0;
      cpu_req(1'b1, 32'h000, 64'h1234_5678_9ABC_DEF0, 1'b0, "de_wr000");
      cpu_req(1'b0, 32'h040, 64'h0, 1'b0, "de_rd040");
      ev0 = log_q.size();
      cpu_req(1'b0, 32'h080, 64'h0, 1'b0, "de_rd080");
      chk("de_two_memops", 128'(log_q.size() - ev0), 128'(2));
      if (log_q.size() >= ev0 + 2) begin
         chk("de_first_is_write", 128'(log_q[ev0].wr), 128'(1));
         chk("de_wb_addr", 128'(log_q[ev0].addr), 128'(32'h000));
         chk("de_wb_word0", 128'(log_q[ev0].data[63:0]), 128'(64'h1234_5678_9ABC_DEF0));
         chk("de_wb_word1", 128'(log_q[ev0].data[127:64]), 128'(64'hAAAA_BBBB_CCCC_DDDD));
         chk("de_then_read", 128'(log_q[ev0 + 1].wr), 128'(0));
         chk("de_read_addr", 128'(log_q[ev0 + 1].addr), 128'(32'h080));
      end
      do_reset();
      mem_lat = 1;
      cpu_req(1'b0, 32'h000, 64'h0, 1'b0, "de_rd000_from_mem");
      chk("de_written_back_value", 128'(cpu.read_data), 128'(64'h1234_5678_9ABC_DEF0));

      // Reset asserted in the middle of a fill
      do_reset();
      mem_lat = 50;
      @(negedge clk);
      cpu.mem_read = 1'b1;
      cpu.address  = 32'h100;
      cyc = 0;
      while (!mem_read_out && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("ma_alloc_strobe", 128'(mem_read_out), 128'(1));
      chk("ma_miss_high", 128'(cpu.miss), 128'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("ma_async_strobes", 128'({mem_read_out, mem_write_out}), 128'(0));
      chk("ma_async_miss", 128'(cpu.miss), 128'(0));
      chk("ma_async_counters", 128'({hit_count, miss_count}), 128'(0));
      cpu.mem_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      shadow.delete();
      exp_q.delete();
      rd_model = '0;
      mem_lat = 1;
      cpu_req(1'b0, 32'h100, 64'h0, 1'b0, "ma_rd100_again");
      chk("ma_miss_count", 128'(miss_count), 128'(1));
      chk("ma_hit_count", 128'(hit_count), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cache_dados_nway.md
CACHE_DADOS_NWAY -- requirements
Module: cache_dados_nway

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 32, byte address width; WORD_W, 64, CPU word width; BLOCK_WORDS, 2, words per block (power of 2); SETS, 4, number of sets (power of 2); WAYS, 2, associativity (1, 2 or 4).
REQ-002 Derived widths SHALL be: BLOCK_W = WORD_W*BLOCK_WORDS; offset = log2(WORD_W/8)+log2(BLOCK_WORDS) bits; index = log2(SETS) bits; tag = remaining upper bits.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  reset, asynchronous and active-low.
REQ-005 mem_read, mem_write  in  1 each  CPU read/write request; held until ready.
REQ-006 address  in  ADDR_W  CPU byte address; write_data  in  WORD_W  CPU store data.
REQ-007 read_data  out  WORD_W  registered load data; ready  out  1  one-cycle completion pulse; miss  out  1  high while a miss is in service.
REQ-008 mem_address  out  ADDR_W  block-aligned memory address; mem_write_data  out  BLOCK_W  victim block.
REQ-009 mem_block_read_data  in  BLOCK_W  fill data; mem_ready  in  1  memory completion; mem_read_out, mem_write_out  out  1  memory strobes.
REQ-010 hit_count, miss_count  out  32 each  wrapping statistics counters.

Function
REQ-011 FSM states SHALL be IDLE, COMPARE, WRITEBACK, ALLOCATE.
REQ-012 IDLE: a request SHALL be accepted on an edge where mem_read|mem_write=1 and ready=0; address/data/op latched; go to COMPARE.
REQ-013 mem_read and mem_write both high SHALL be treated as a write.
REQ-014 COMPARE hit (valid and tag match in any way): next edge SHALL return to IDLE, set ready=1 for exactly one cycle, update LRU; on a read, read_data <= selected word (word index = address offset bits above the byte offset, word 0 = block bits [WORD_W-1:0]).
REQ-015 Write hit: the selected word SHALL be replaced by write_data, dirty=1; read_data unchanged.
REQ-016 Hit latency SHALL be 2 edges from acceptance to ready; minimum request spacing is 3 cycles.
REQ-017 COMPARE miss: victim = lowest-numbered invalid way, else the LRU way; go to WRITEBACK if victim is valid and dirty, else ALLOCATE; miss=1 from this edge until fill completes.
REQ-018 WRITEBACK: mem_write_out=1, mem_address={victim tag, index, offset 0}, mem_write_data=victim block; on mem_ready=1, next edge clears the strobe and enters ALLOCATE.
REQ-019 ALLOCATE: mem_read_out=1, mem_address={request tag, index, offset 0}; on mem_ready=1, the victim way is written with mem_block_read_data, tag set, valid=1, dirty=0; go to COMPARE, which then hits.
REQ-020 mem_ready SHALL be ignored outside WRITEBACK/ALLOCATE; memory may answer in the same cycle as the strobe.
REQ-021 LRU: per-way age of log2(WAYS) bits per set; accessed way set to 0, ways younger than its old age incremented; WAYS=1 always selects way 0.
REQ-022 Exactly one of hit_count/miss_count SHALL increment per accepted request, on its first COMPARE only; the post-fill re-lookup SHALL not count.

Reset
REQ-023 reset=0 SHALL immediately clear all valid, dirty and LRU bits, the counters, ready, miss, read_data, mem strobes and mem_address, and force IDLE, including mid-WRITEBACK/ALLOCATE; dirty data is discarded.
REQ-024 Tag/data arrays need not be cleared.

Verification (defaults; memory block 0x000 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222; set stride 0x40)
REQ-025 Reset -> all outputs 0, state IDLE, counters 0.
REQ-026 Read 0x000 -> one mem_read_out at 0x000, read_data=64'hEEEE_FFFF_1111_2222, miss_count=1; then read 0x008 -> no memory strobe, ready 2 edges after acceptance, read_data=64'hAAAA_BBBB_CCCC_DDDD, hit_count=1.
REQ-027 Write 0x000 with 64'h1234_5678_9ABC_DEF0 (hit) -> no memory traffic; read 0x000 returns 64'h1234_5678_9ABC_DEF0.
REQ-028 Clean conflict: read 0x000, 0x040, 0x000, 0x080 -> 0x080 evicts 0x040 (LRU) with no mem_write_out; read 0x000 then hits.
REQ-029 Dirty eviction: write 0x000, read 0x040, read 0x080 -> mem_write_out at 0x000 with mem_write_data[63:0]=written word, before mem_read_out at 0x080.
REQ-030 Reset asserted while in ALLOCATE -> strobes and miss drop asynchronously; a later read of the same address misses again (miss_count=1 after reset).
